case_convert_stream: RTL and testbench

//  Streaming ASCII case converter: the parametrised successor to the single-byte toupper path.

---
 rtl/case_pkg.sv | 25 ++
 rtl/case_lane_conv.sv | 46 ++++
 rtl/case_convert_stream.sv | 167 ++++++++++++++++
 tb/tb_case_convert_stream.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/case_pkg.sv
// Shared types and character constants for the streaming ASCII case converter.
package case_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_UPPER = 2'd1,
        MODE_LOWER = 2'd2,
        MODE_TITLE = 2'd3
    } mode_e;

    localparam logic [7:0] CH_UA    = 8'h41;
    localparam logic [7:0] CH_UZ    = 8'h5A;
    localparam logic [7:0] CH_LA    = 8'h61;
    localparam logic [7:0] CH_LZ    = 8'h7A;
    localparam logic [7:0] CASE_BIT = 8'h20;

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= CH_UA) && (c <= CH_UZ);
    endfunction

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= CH_LA) && (c <= CH_LZ);
    endfunction

endpackage

// File: rtl/case_lane_conv.sv
// One-character case converter; letters only ever have the case bit flipped.
module case_lane_conv
    import case_pkg::*;
(
    input  logic [7:0] in_byte,
    input  mode_e      mode,
    input  logic       prev_is_alpha,
    output logic [7:0] out_byte,
    output logic       is_alpha,
    output logic       changed
);

    logic upper;
    logic lower;
    logic to_upper;
    logic to_lower;

    assign upper    = is_upper(in_byte);
    assign lower    = is_lower(in_byte);
    // Kept separate from the conversion so lane-to-lane chaining has no false loop.
    assign is_alpha = upper | lower;

    always_comb begin
        to_upper = 1'b0;
        to_lower = 1'b0;
        unique case (mode)
            MODE_PASS: begin
            end
            MODE_UPPER: to_upper = lower;
            MODE_LOWER: to_lower = upper;
            MODE_TITLE: begin
                to_upper = lower & ~prev_is_alpha;
                to_lower = upper & prev_is_alpha;
            end
        endcase

        out_byte = in_byte;
        if (to_upper) begin
            out_byte = in_byte & ~CASE_BIT;
        end else if (to_lower) begin
            out_byte = in_byte | CASE_BIT;
        end
        changed = to_upper | to_lower;
    end

endmodule

// File: rtl/case_convert_stream.sv
// Multi-lane ASCII case converter on a valid/ready stream with a 2-entry skid output
// buffer and a saturating count of converted characters.
module case_convert_stream
    import case_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic [LANES-1:0]   in_keep,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic [LANES-1:0]   out_keep,
    output logic               out_last,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   conv_count
);

    localparam int unsigned INC_W = $clog2(LANES + 1);
    localparam int unsigned SUM_W = CNT_W + INC_W;

    mode_e              mode_cur;
    logic [LANES-1:0]   lane_prev;
    logic [LANES-1:0]   lane_alpha;
    logic [LANES-1:0]   lane_changed;
    logic [8*LANES-1:0] conv_data;
    logic               beat_prev;
    logic [INC_W-1:0]   inc;
    logic               accept;
    logic               xfer;

    logic               out_valid_q, out_valid_d;
    logic [8*LANES-1:0] out_data_q, out_data_d;
    logic [LANES-1:0]   out_keep_q, out_keep_d;
    logic               out_last_q, out_last_d;
    logic               skid_valid_q, skid_valid_d;
    logic [8*LANES-1:0] skid_data_q, skid_data_d;
    logic [LANES-1:0]   skid_keep_q, skid_keep_d;
    logic               skid_last_q, skid_last_d;
    logic               prev_alpha_q, prev_alpha_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_base;
    logic [SUM_W-1:0]   cnt_sum;

    assign mode_cur = mode_e'(mode);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [7:0] conv_byte;

        case_lane_conv u_conv (
            .in_byte      (in_data[8*i +: 8]),
            .mode         (mode_cur),
            .prev_is_alpha(lane_prev[i]),
            .out_byte     (conv_byte),
            .is_alpha     (lane_alpha[i]),
            .changed      (lane_changed[i])
        );

        assign conv_data[8*i +: 8] = in_keep[i] ? conv_byte : in_data[8*i +: 8];
    end

    // Non-kept lanes are transparent to word context.
    always_comb begin
        beat_prev = prev_alpha_q;
        lane_prev = '0;
        inc       = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_prev[i] = beat_prev;
            if (in_keep[i]) begin
                beat_prev = lane_alpha[i];
                inc       = inc + INC_W'(lane_changed[i]);
            end
        end
    end

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign xfer     = out_valid_q & out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_keep_d  = skid_keep_q;
        skid_last_d  = skid_last_q;

        if (skid_valid_q) begin
            // in_ready is low here, so only a drain can happen.
            if (xfer) begin
                out_data_d   = skid_data_q;
                out_keep_d   = skid_keep_q;
                out_last_d   = skid_last_q;
                skid_valid_d = 1'b0;
            end
        end else if (!out_valid_q || xfer) begin
            out_valid_d = accept;
            if (accept) begin
                out_data_d = conv_data;
                out_keep_d = in_keep;
                out_last_d = in_last;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = conv_data;
            skid_keep_d  = in_keep;
            skid_last_d  = in_last;
        end
    end

    always_comb begin
        prev_alpha_d = prev_alpha_q;
        if (accept) begin
            prev_alpha_d = in_last ? 1'b0 : beat_prev;
        end

        cnt_base = cnt_clr ? '0 : cnt_q;
        cnt_sum  = SUM_W'(cnt_base) + (accept ? SUM_W'(inc) : '0);
        if (|cnt_sum[SUM_W-1:CNT_W]) begin
            cnt_d = '1;
        end else begin
            cnt_d = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_keep_q  <= '0;
            skid_last_q  <= 1'b0;
            prev_alpha_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_keep_q  <= skid_keep_d;
            skid_last_q  <= skid_last_d;
            prev_alpha_q <= prev_alpha_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_keep   = out_keep_q;
    assign out_last   = out_last_q;
    assign conv_count = cnt_q;

endmodule

// File: tb/tb_case_convert_stream.sv
// Bench for case_convert_stream: directed table, corner sequences and random traffic
// against a character-level reference model with a depth-2 FIFO view of the buffer.
module tb_case_convert_stream;

    localparam int LANES   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         mode;
    logic               in_valid;
    logic               in_ready;
    logic [8*LANES-1:0] in_data;
    logic [LANES-1:0]   in_keep;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [8*LANES-1:0] out_data;
    logic [LANES-1:0]   out_keep;
    logic               out_last;
    logic               cnt_clr;
    logic [CNT_W-1:0]   conv_count;

    always #5 clk = ~clk;

    case_convert_stream #(
        .LANES(LANES),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .cnt_clr   (cnt_clr),
        .conv_count(conv_count)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        logic [1:0]  md;
        logic [31:0] din;
        logic [3:0]  keep;
        logic        last;
        logic        clr;
        logic [31:0] dexp;
        int          cexp;
    } vec_t;

    int    n_vec  = 0;
    int    n_miss = 0;
    beat_t q[$];
    logic  m_prev = 1'b0;
    int    m_cnt  = 0;
    vec_t  tv[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] s2w(input string s);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            w[8*i +: 8] = (i < s.len()) ? s[i] : 8'h2d;
        end
        return w;
    endfunction

    // Character-level model: walk the kept characters in order, applying the mode rules.
    task automatic ref_beat(input logic [31:0] din, input logic [3:0] keep, input logic [1:0] md,
                            input logic prev_in, output logic [31:0] dout, output int inc,
                            output logic prev_out);
        logic       p;
        logic [7:0] c;
        logic [7:0] r;
        logic       up;
        logic       lo;
        p    = prev_in;
        inc  = 0;
        dout = din;
        for (int i = 0; i < 4; i++) begin
            c = din[8*i +: 8];
            r = c;
            if (keep[i]) begin
                up = (c >= "A") && (c <= "Z");
                lo = (c >= "a") && (c <= "z");
                case (md)
                    2'd1: if (lo) r = c - 8'd32;
                    2'd2: if (up) r = c + 8'd32;
                    2'd3: begin
                        if (p && up) r = c + 8'd32;
                        if (!p && lo) r = c - 8'd32;
                    end
                    default: r = c;
                endcase
                if (r != c) inc++;
                p = up || lo;
            end
            dout[8*i +: 8] = r;
        end
        prev_out = p;
    endtask

    // Advance model and DUT by one clock, then compare everything visible.
    task automatic cycle();
        logic [31:0] d;
        int          inc;
        logic        pn;
        logic        acc;
        logic        xf;
        beat_t       b;
        if (rst) begin
            q.delete();
            m_prev = 1'b0;
            m_cnt  = 0;
        end else begin
            acc = in_valid && (q.size() < 2);
            xf  = (q.size() > 0) && out_ready;
            ref_beat(in_data, in_keep, mode, m_prev, d, inc, pn);
            if (xf) b = q.pop_front();
            if (acc) begin
                b.data = d;
                b.keep = in_keep;
                b.last = in_last;
                q.push_back(b);
                m_prev = in_last ? 1'b0 : pn;
            end
            if (cnt_clr) m_cnt = 0;
            if (acc) m_cnt = (m_cnt + inc > CNT_MAX) ? CNT_MAX : m_cnt + inc;
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("conv_count", 32'(conv_count), 32'(m_cnt));
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].data);
            chk("out_keep", 32'(out_keep), 32'(q[0].keep));
            chk("out_last", 32'(out_last), 32'(q[0].last));
        end
    endtask

    task automatic drive(input logic [1:0] md, input logic [31:0] d, input logic [3:0] k,
                         input logic l, input logic iv, input logic ordy, input logic clr);
        mode      = md;
        in_data   = d;
        in_keep   = k;
        in_last   = l;
        in_valid  = iv;
        out_ready = ordy;
        cnt_clr   = clr;
    endtask

    function automatic logic [7:0] rnd_char();
        case ($urandom_range(0, 3))
            0:       return 8'($urandom_range(8'h40, 8'h5b));
            1:       return 8'($urandom_range(8'h60, 8'h7b));
            2:       return ($urandom_range(0, 1) == 0) ? 8'h20 : 8'($urandom_range(8'h30, 8'h39));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        logic [31:0] rd;

        // Reset
        rst = 1'b1;
        drive(2'd0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_keep", 32'(out_keep), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_count", 32'(conv_count), 32'd0);

        // Directed table, out_ready held high
        tv[0] = '{2'd1, s2w("aZ1{"), 4'b1111, 1'b0, 1'b1, s2w("AZ1{"), 1};
        tv[1] = '{2'd1, {8'h7b, 8'h60, 8'h5b, 8'h40}, 4'b1111, 1'b0, 1'b0,
                  {8'h7b, 8'h60, 8'h5b, 8'h40}, 1};
        tv[2] = '{2'd3, s2w("helz"), 4'b0111, 1'b0, 1'b0, s2w("Helz"), 2};
        tv[3] = '{2'd3, s2w("lo w"), 4'b1111, 1'b1, 1'b0, s2w("lo W"), 3};
        tv[4] = '{2'd3, s2w("x---"), 4'b0001, 1'b0, 1'b0, s2w("X---"), 4};
        tv[5] = '{2'd2, s2w("AbCd"), 4'b1010, 1'b0, 1'b0, s2w("AbCd"), 4};
        tv[6] = '{2'd0, s2w("ABCD"), 4'b1111, 1'b0, 1'b0, s2w("ABCD"), 4};
        tv[7] = '{2'd2, s2w("AbCd"), 4'b1111, 1'b1, 1'b0, s2w("abcd"), 6};
        tv[8] = '{2'd3, s2w("hELL"), 4'b1111, 1'b0, 1'b0, s2w("Hell"), 10};
        for (int i = 0; i < 9; i++) begin
            drive(tv[i].md, tv[i].din, tv[i].keep, tv[i].last, 1'b1, 1'b1, tv[i].clr);
            cycle();
            chk("tv_valid", 32'(out_valid), 32'd1);
            chk("tv_data", out_data, tv[i].dexp);
            chk("tv_count", 32'(conv_count), 32'(tv[i].cexp));
        end
        drive(2'd0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();

        // Backpressure: two beats buffer, third waits, order preserved on release
        drive(2'd1, s2w("aaaa"), 4'hf, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("bp_ready1", 32'(in_ready), 32'd1);
        drive(2'd1, s2w("bbbb"), 4'hf, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("bp_ready2", 32'(in_ready), 32'd0);
        drive(2'd1, s2w("cccc"), 4'hf, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("bp_ready3", 32'(in_ready), 32'd0);
        chk("bp_hold", out_data, s2w("AAAA"));
        out_ready = 1'b1;
        cycle();
        chk("bp_rel1", out_data, s2w("BBBB"));
        cycle();
        chk("bp_rel2", out_data, s2w("CCCC"));
        in_valid = 1'b0;
        cycle();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Reset with the skid buffer full, then a fresh TITLE message
        drive(2'd0, s2w("zzzz"), 4'hf, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        cycle();
        rst      = 1'b1;
        in_valid = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 32'd0);
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        chk("t1_count", 32'(conv_count), 32'd0);
        drive(2'd3, s2w("ab--"), 4'b0011, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle();
        chk("t1_title", out_data, s2w("Ab--"));

        // Saturation and clear-with-accept
        drive(2'd1, s2w("abcd"), 4'hf, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle();
        chk("sat_clr", 32'(conv_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(2'd1, s2w("abcd"), 4'hf, 1'b0, 1'b1, 1'b1, 1'b0);
            cycle();
        end
        chk("sat_hold", 32'(conv_count), 32'd15);
        drive(2'd1, s2w("ab12"), 4'hf, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle();
        chk("sat_clr_add", 32'(conv_count), 32'd2);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            for (int l = 0; l < 4; l++) rd[8*l +: 8] = rnd_char();
            drive(2'($urandom_range(0, 3)), rd, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0));
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;
        drive(2'd0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
